exponent_accelerator_pio_in: RTL and testbench

// - Parametrised Avalon-MM input PIO: switches/keys -> Nios II. Synchronises and debounces WIDTH inputs.
// - Latches per-bit edges into a sticky edge-capture register; raises a maskable level IRQ.
// - Successor to the fixed 10-bit data-only switch port; register 0 layout is unchanged, so existing drivers still work.

---
 rtl/exponent_pio_pkg.sv | 13 +
 rtl/exponent_pio_debounce_bit.sv | 44 ++++
 rtl/exponent_accelerator_pio_in.sv | 101 ++++++++++
 tb/tb_exponent_accelerator_pio_in.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/exponent_pio_pkg.sv
// Shared register offsets and edge-mode encodings for the exponent accelerator input PIO.
package exponent_pio_pkg;

  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_RAW     = 2'd1;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/exponent_pio_debounce_bit.sv
// One-bit debounce filter: the output follows the synchronised input only after it
// has differed from the current output for DEBOUNCE_CYCLES consecutive cycles.
module exponent_pio_debounce_bit
  import exponent_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic s2,
  output logic filt
);

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt = s2;
    end else begin : g_filter
      localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt;
      logic             filt_q;

      // Counter restarts whenever the input agrees with the accepted value,
      // so only an unbroken run of disagreement is ever accepted.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt    <= '0;
          filt_q <= 1'b0;
        end else if (s2 == filt_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          filt_q <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

endmodule

// File: rtl/exponent_accelerator_pio_in.sv
// Avalon-MM input PIO: synchronised, debounced inputs with sticky edge capture
// and a maskable level interrupt. Offset 0 keeps the legacy data-port layout.
module exponent_accelerator_pio_in
  import exponent_pio_pkg::*;
#(
  parameter int               WIDTH           = 10,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_MODE       = EDGE_RISE,
  parameter logic [WIDTH-1:0] IRQ_RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edgecap_kept;
  logic [WIDTH-1:0] irqmask;
  logic [31:0]      rd_mux;

  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = ^writedata[31:WIDTH];
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    exponent_pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .s2   (s2[i]),
      .filt (filt[i])
    );
  end

  always_comb begin
    rise = filt & ~filt_d;
    fall = ~filt & filt_d;
    case (EDGE_MODE)
      EDGE_FALL: edge_det = fall;
      EDGE_ANY:  edge_det = rise | fall;
      default:   edge_det = rise;
    endcase
  end

  // The clear is applied before the new edge is OR-ed in, so a same-cycle set survives.
  always_comb begin
    edgecap_kept = edgecap;
    if (write && (address == PIO_EDGECAP)) begin
      edgecap_kept = edgecap & ~writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_DATA:    rd_mux[WIDTH-1:0] = filt;
      PIO_RAW:     rd_mux[WIDTH-1:0] = s2;
      PIO_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      default:     rd_mux[WIDTH-1:0] = edgecap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      filt_d   <= '0;
      edgecap  <= '0;
      irqmask  <= IRQ_RESET_MASK;
      readdata <= '0;
    end else begin
      s1       <= in_port;
      s2       <= s1;
      filt_d   <= filt;
      edgecap  <= edgecap_kept | edge_det;
      readdata <= rd_mux;
      if (write && (address == PIO_IRQMASK)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_exponent_accelerator_pio_in.sv
// Bench for the input PIO: three edge-mode builds driven in parallel and checked
// against a history-window behavioural model, plus directed timing scenarios.
module tb_exponent_accelerator_pio_in;

  localparam int W  = 10;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          write;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_rise, rd_fall, rd_any;
  logic          irq_rise, irq_fall, irq_any;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  exponent_accelerator_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(0), .IRQ_RESET_MASK('0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_rise), .in_port(in_port), .irq(irq_rise));
  exponent_accelerator_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(1), .IRQ_RESET_MASK('0)) u_fall (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_fall), .in_port(in_port), .irq(irq_fall));
  exponent_accelerator_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(2), .IRQ_RESET_MASK('0)) u_any (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_any), .in_port(in_port), .irq(irq_any));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: an input is accepted once its last DB synchronised samples
  // all disagree with the accepted value; edges and registers follow the register map.
  logic [W-1:0]  m_s1 = '0, m_s2 = '0, m_filt = '0, m_filtd = '0, m_mask = '0;
  logic [W-1:0]  m_ec [3];
  logic [31:0]   m_rd [3];
  logic [DB-1:0] m_hist [W];
  logic [DB-1:0] h_new [W];
  logic [W-1:0]  n_filt;
  logic [W-1:0]  ev [3];

  function automatic logic [31:0] reg_value(int k, logic [1:0] a);
    case (a)
      2'd0:    return {22'b0, m_filt};
      2'd1:    return {22'b0, m_s2};
      2'd2:    return {22'b0, m_mask};
      default: return {22'b0, m_ec[k]};
    endcase
  endfunction

  always_comb begin
    n_filt = m_filt;
    ev[0]  = m_filt & ~m_filtd;
    ev[1]  = ~m_filt & m_filtd;
    ev[2]  = m_filt ^ m_filtd;
    for (int i = 0; i < W; i++) begin
      h_new[i] = {m_hist[i][DB-2:0], m_s2[i]};
      if (h_new[i] == {DB{~m_filt[i]}}) n_filt[i] = ~m_filt[i];
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_filt <= '0; m_filtd <= '0; m_mask <= '0;
      for (int k = 0; k < 3; k++) begin m_ec[k] <= '0; m_rd[k] <= '0; end
      for (int i = 0; i < W; i++) m_hist[i] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_rd[k] <= reg_value(k, address);
        m_ec[k] <= ((write && address == 2'd3) ? (m_ec[k] & ~writedata[W-1:0]) : m_ec[k]) | ev[k];
      end
      for (int i = 0; i < W; i++) m_hist[i] <= h_new[i];
      m_filt  <= n_filt;
      m_filtd <= m_filt;
      m_s2    <= m_s1;
      m_s1    <= in_port;
      if (write && address == 2'd2) m_mask <= writedata[W-1:0];
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("model_rd_rise", rd_rise, m_rd[0]);
      chk("model_rd_fall", rd_fall, m_rd[1]);
      chk("model_rd_any",  rd_any,  m_rd[2]);
      chk("model_irq_rise", {31'b0, irq_rise}, {31'b0, |(m_ec[0] & m_mask)});
      chk("model_irq_fall", {31'b0, irq_fall}, {31'b0, |(m_ec[1] & m_mask)});
      chk("model_irq_any",  {31'b0, irq_any},  {31'b0, |(m_ec[2] & m_mask)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  // After reset release DATA must hold 0 on the 6th edge and the input on the 7th.
  task automatic release_check(input string tag, input logic [W-1:0] expv);
    address = 2'd0;
    for (int k = 1; k <= DB + 3; k++) begin
      tick();
      @(negedge clk);
      if (k == DB + 2) chk({tag, "_early"}, rd_rise, 32'h0);
      if (k == DB + 3) chk({tag, "_data"}, rd_rise, {22'b0, expv});
    end
  endtask

  initial begin
    bit saw;
    int hold;
    reset = 1'b1; address = 2'd0; write = 1'b0; writedata = '0; in_port = 10'h3FF;
    tick();
    run = 1'b1;
    @(negedge clk);
    chk("reset_rd", rd_rise, 32'h0);
    chk("reset_irq", {31'b0, irq_rise}, 32'h0);
    tick();
    reset = 1'b0;
    release_check("reset_release", 10'h3FF);

    in_port = '0;
    repeat (12) tick();
    wr(2'd3, 32'h3FF);

    // Glitch filtering
    in_port[0] = 1'b1; repeat (3) tick(); in_port[0] = 1'b0;
    repeat (10) tick();
    address = 2'd3; tick(); @(negedge clk);
    chk("glitch_edgecap", rd_rise, 32'h0);
    address = 2'd0; saw = 1'b0;
    in_port[0] = 1'b1; repeat (4) tick(); in_port[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); @(negedge clk); saw |= rd_rise[0]; end
    chk("pulse_data0", {31'b0, saw}, 32'h1);
    address = 2'd3; tick(); @(negedge clk);
    chk("pulse_edgecap", rd_rise, 32'h001);

    // Interrupt path and RAW latency
    wr(2'd3, 32'h3FF);
    wr(2'd2, 32'h002);
    address = 2'd1; in_port = 10'h002;
    tick(); tick(); @(negedge clk);
    chk("raw_early", rd_rise, 32'h0);
    tick(); @(negedge clk);
    chk("raw_data", rd_rise, 32'h002);
    repeat (8) tick();
    address = 2'd3; tick(); @(negedge clk);
    chk("irq_edgecap", rd_rise, 32'h002);
    chk("irq_set", {31'b0, irq_rise}, 32'h1);
    wr(2'd3, 32'h2);
    @(negedge clk);
    chk("irq_clear", {31'b0, irq_rise}, 32'h0);

    // Same-cycle set and clear on bit 3
    in_port = 10'h00A;
    repeat (DB + 2) tick();
    address = 2'd3; writedata = 32'h8; write = 1'b1;
    tick();
    write = 1'b0;
    tick(); @(negedge clk);
    chk("race_edgecap3", rd_rise & 32'h8, 32'h8);
    chk("race_irq", {31'b0, irq_rise}, 32'h0);

    // Reset while bit 5 is part-way through debouncing
    in_port = 10'h02A;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midreset_rd", rd_rise, 32'h0);
    reset = 1'b0;
    release_check("midreset_release", 10'h02A);

    // Edge-mode sweep on bit 9
    repeat (4) tick();
    wr(2'd3, 32'h3FF);
    in_port[9] = 1'b1;
    repeat (12) tick();
    tick(); @(negedge clk);
    chk("sweep_rise_rise", rd_rise, 32'h200);
    chk("sweep_rise_fall", rd_fall, 32'h000);
    chk("sweep_rise_any",  rd_any,  32'h200);
    wr(2'd3, 32'h3FF);
    in_port[9] = 1'b0;
    repeat (12) tick();
    tick(); @(negedge clk);
    chk("sweep_fall_rise", rd_rise, 32'h000);
    chk("sweep_fall_fall", rd_fall, 32'h200);
    chk("sweep_fall_any",  rd_any,  32'h200);

    // Read-only registers ignore writes
    wr(2'd0, 32'h3FF);
    wr(2'd1, 32'h3FF);
    address = 2'd0; tick(); @(negedge clk);
    chk("ro_data", rd_rise, 32'h02A);
    address = 2'd1; tick(); @(negedge clk);
    chk("ro_raw", rd_rise, 32'h02A);

    // Randomised traffic against the model
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        in_port = in_port ^ W'($urandom & $urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      write     = ($urandom_range(0, 5) == 0);
      address   = 2'($urandom);
      writedata = $urandom;
      reset     = ($urandom_range(0, 150) == 0);
      tick();
    end
    write = 1'b0; reset = 1'b0;
    repeat (12) tick();

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
